// File: rtl/poly_decompress_unpack_pkg.sv
// Shared Kyber constants, FSM state type and depth helpers for the streaming decompressor.
// Only the five standard compression depths are treated as legal.
package poly_decompress_unpack_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;

  localparam logic [3:0] D1  = 4'd1;
  localparam logic [3:0] D4  = 4'd4;
  localparam logic [3:0] D5  = 4'd5;
  localparam logic [3:0] D10 = 4'd10;
  localparam logic [3:0] D11 = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // 256 coefficients of d bits each pack into exactly 32*d bytes
  function automatic logic [8:0] poly_bytes(input logic [3:0] d);
    return {d, 5'b0};
  endfunction

  function automatic logic d_legal(input logic [3:0] d);
    return (d == D1) || (d == D4) || (d == D5) || (d == D10) || (d == D11);
  endfunction

endpackage

// File: rtl/poly_decompress_unpack_decompress_var.sv
// Combinational Decompress_q for a run-time depth: round(q*y / 2^d) into 12 bits.
// Zero latency; no flow control of its own.
module decompress_var
  import poly_decompress_unpack_pkg::*;
(
  input  logic [3:0]  d,
  input  logic [10:0] y,
  output logic [11:0] result
);

  logic [22:0] prod;
  logic [22:0] sum;
  logic [22:0] rnd;

  // 3329 * 2047 plus the largest rounding term still fits in 23 bits
  assign prod = 23'(y) * 23'(KYBER_Q);
  assign sum  = prod + rnd;

  always_comb begin
    rnd    = '0;
    result = '0;
    case (d)
      D1:  begin rnd = 23'd1;    result = 12'(sum >> 1);  end
      D4:  begin rnd = 23'd8;    result = 12'(sum >> 4);  end
      D5:  begin rnd = 23'd16;   result = 12'(sum >> 5);  end
      D10: begin rnd = 23'd512;  result = 12'(sum >> 10); end
      D11: begin rnd = 23'd1024; result = 12'(sum >> 11); end
      default: begin rnd = '0; result = '0; end
    endcase
  end

endmodule

// File: rtl/poly_decompress_unpack.sv
// Streaming ByteDecode_d + Decompress_q of one 256-coefficient polynomial, d in {1,4,5,10,11}.
// A coefficient is valid the cycle after its last bit is accepted; out_ready=0 stalls extraction while the buffer fills.
module poly_decompress_unpack
  import poly_decompress_unpack_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int N_COEF = 256,
  parameter int BUF_W  = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      d_sel,
  output logic            busy,
  output logic            err,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [11:0]     out_coef,
  output logic [7:0]      out_idx,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            done
);

  // wide enough that cnt + IN_W never wraps before the headroom compare
  localparam int CNT_W = $clog2(BUF_W + IN_W + 1);

  state_t            state_q, state_d;
  logic [3:0]        d_q;
  logic [BUF_W-1:0]  buf_q, merged, buf_next;
  logic [CNT_W-1:0]  cnt_q, mcnt, cnt_next;
  logic [8:0]        bytes_q;
  logic [8:0]        coef_q;
  logic              err_q;

  logic              byte_ok, acc, take, slot_free, last_hs;
  logic              start_ok, start_bad;
  logic [10:0]       y;
  logic [11:0]       coef_res;

  assign byte_ok   = (bytes_q < poly_bytes(d_q)) &&
                     ((cnt_q + CNT_W'(IN_W)) <= CNT_W'(BUF_W));
  assign acc       = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign last_hs   = out_valid && out_ready && out_last;
  assign err       = err_q;

  // A byte arriving this cycle is merged first so its bits can be extracted immediately
  always_comb begin
    merged   = buf_q;
    mcnt     = cnt_q;
    if (acc) begin
      merged = buf_q | (BUF_W'(in_data) << cnt_q);
      mcnt   = cnt_q + CNT_W'(IN_W);
    end
    take     = (state_q == ST_RUN) && (coef_q < 9'(N_COEF)) &&
               (mcnt >= CNT_W'(d_q)) && slot_free;
    y        = merged[10:0] & ((11'd1 << d_q) - 11'd1);
    buf_next = merged;
    cnt_next = mcnt;
    if (take) begin
      buf_next = merged >> d_q;
      cnt_next = mcnt - CNT_W'(d_q);
    end
  end

  decompress_var u_dec (
    .d      (d_q),
    .y      (y),
    .result (coef_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (d_legal(d_sel)) begin
            start_ok = 1'b1;
            state_d  = ST_RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = byte_ok;
        if (last_hs) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      bytes_q   <= '0;
      coef_q    <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        d_q     <= d_sel;
        buf_q   <= '0;
        cnt_q   <= '0;
        bytes_q <= '0;
        coef_q  <= '0;
      end else if (state_q == ST_RUN) begin
        buf_q <= buf_next;
        cnt_q <= cnt_next;
        if (acc)  bytes_q <= bytes_q + 9'd1;
        if (take) coef_q  <= coef_q + 9'd1;
      end
      if (take) begin
        out_valid <= 1'b1;
        out_coef  <= coef_res;
        out_idx   <= coef_q[7:0];
        out_last  <= (coef_q == 9'(N_COEF - 1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_decompress_unpack.sv
// Directed bench for poly_decompress_unpack: hand-computed coefficients plus a bit-level reference.
// Covers all-ones depths, backpressure with gapped input, illegal/overlapping starts and mid-run reset.
module tb_poly_decompress_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  d_sel = 4'd0;
  logic        busy, err;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] out_coef;
  logic [7:0]  out_idx;
  logic        out_last, out_valid;
  logic        out_ready = 1'b0;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  pbytes [0:399];
  int          nbytes;
  logic [11:0] got_coef [0:255];

  always #5 clk = ~clk;

  poly_decompress_unpack dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_sel(d_sel), .busy(busy), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_coef(out_coef), .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference ByteDecode_d (LSB-first) followed by rounded Decompress_q
  function automatic int model(input int i, input int d);
    int y = 0;
    for (int b = 0; b < d; b++) begin
      int pos = i * d + b;
      logic [7:0] bv = pbytes[pos / 8];
      if (bv[pos % 8]) y |= (1 << b);
    end
    return (3329 * y + (1 << (d - 1))) >> d;
  endfunction

  // n payload bytes of v (or random when rnd), then 4 trailing bytes that must never be taken
  task automatic fill(input int n, input logic [7:0] v, input bit rnd);
    for (int i = 0; i < n; i++) pbytes[i] = rnd ? 8'($urandom_range(255)) : v;
    for (int i = n; i < n + 4; i++) pbytes[i] = 8'hFF;
    nbytes = n + 4;
  endtask

  task automatic start_poly(input logic [3:0] d);
    @(posedge clk); #1;
    start = 1'b1; d_sel = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_poly(input int d, input bit gaps, input bit bp, input int busy_start_at,
                          input int abort_idx, input bit start_on_done);
    int nacc = 0, ngot = 0, cyc = 0, bc;
    bit stalled = 1'b0, fin = 1'b0, saw_last = 1'b0, aborted = 1'b0;
    logic [11:0] h_coef = '0;
    logic [7:0]  h_idx = '0;
    logic        h_last = 1'b0;
    start_poly(4'(d));
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (saw_last) begin
        chk("done_pulse", done, 1);
        chk("busy_drop", busy, 0);
        chk("out_valid_after_last", out_valid, 0);
        fin = 1'b1;
      end else begin
        chk("no_early_done", done, 0);
        chk("err_quiet", err, 0);
        if (stalled)
          chk("hold_stable", {out_valid, out_last, out_idx, out_coef}, {1'b1, h_last, h_idx, h_coef});
        stalled = out_valid && !out_ready;
        h_coef = out_coef; h_idx = out_idx; h_last = out_last;
        bc = 8 * nacc - d * (ngot + int'(out_valid));
        if (in_ready) chk("in_ready_headroom", 32'(int'(bc + 8 <= 24)), 1);
        if (out_valid && out_ready) begin
          chk("out_idx", out_idx, ngot);
          chk("out_coef", out_coef, model(ngot, d));
          chk("out_last", out_last, 32'(int'(ngot == 255)));
          got_coef[ngot] = out_coef;
          if (ngot == 255) saw_last = 1'b1;
          ngot++;
        end
        if (in_valid && in_ready) nacc++;
        if (abort_idx >= 0 && ngot > abort_idx) begin
          rst_n = 1'b0;
          #1;
          chk("rst_outputs", {busy, err, in_ready, out_valid, out_last, done}, 0);
          chk("rst_coef", out_coef, 0);
          chk("rst_idx", out_idx, 0);
          in_valid = 1'b0; out_ready = 1'b0;
          fin = 1'b1; aborted = 1'b1;
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (cyc == busy_start_at) begin start = 1'b1; d_sel = 4'd4; end
        else start = start_on_done && saw_last;
        if (start_on_done && saw_last) d_sel = 4'd5;
        in_valid  = (nacc < nbytes) && (!gaps || $urandom_range(3) != 0);
        in_data   = pbytes[nacc];
        out_ready = !bp || ($urandom_range(1) == 1);
      end
    end
    chk("run_completed", 32'(fin), 1);
    if (!aborted) begin
      chk("bytes_taken", nacc, 32 * d);
      chk("coef_count", ngot, 256);
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {busy, err, in_ready, out_valid, out_last, done}, 0);
    chk("reset_coef", out_coef, 0);
    chk("reset_idx", out_idx, 0);
    rst_n = 1'b1;

    // d=4: 0x5A -> y=0xA,5 ; 0xFF -> y=15,15
    fill(128, 8'h00, 1'b0);
    pbytes[0] = 8'h5A; pbytes[1] = 8'hFF;
    run_poly(4, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("d4_c0", got_coef[0], 2081);
    chk("d4_c1", got_coef[1], 1040);
    chk("d4_c2", got_coef[2], 3121);
    chk("d4_c3", got_coef[3], 3121);
    chk("d4_c4", got_coef[4], 0);

    // d=1, single set bit; a start coinciding with done must be ignored
    fill(32, 8'h00, 1'b0);
    pbytes[0] = 8'h01;
    run_poly(1, 1'b0, 1'b0, -1, -1, 1'b1);
    chk("d1_c0", got_coef[0], 1665);
    chk("d1_c1", got_coef[1], 0);
    chk("d1_c255", got_coef[255], 0);

    fill(320, 8'hFF, 1'b0);
    run_poly(10, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("d10_ones_first", got_coef[0], 3326);
    chk("d10_ones_last", got_coef[255], 3326);

    fill(352, 8'hFF, 1'b0);
    run_poly(11, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("d11_ones_first", got_coef[0], 3327);
    chk("d11_ones_last", got_coef[255], 3327);

    fill(160, 8'hFF, 1'b0);
    run_poly(5, 1'b0, 1'b0, -1, -1, 1'b0);
    chk("d5_ones_first", got_coef[0], 3225);
    chk("d5_ones_last", got_coef[255], 3225);

    // illegal depth
    @(posedge clk); #1;
    start = 1'b1; d_sel = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    chk("err_still_idle", busy, 0);

    // d=11 random data, gapped input, random backpressure, stray start(d=4) mid-run
    fill(352, 8'h00, 1'b1);
    run_poly(11, 1'b1, 1'b1, 40, -1, 1'b0);

    // d=5 aborted by reset at idx 100, then a clean d=4 run
    fill(160, 8'h00, 1'b1);
    run_poly(5, 1'b1, 1'b0, -1, 100, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fill(128, 8'h00, 1'b1);
    run_poly(4, 1'b1, 1'b1, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_decompress_unpack.md
Name: poly_decompress_unpack

Overview:
- Streaming Kyber ByteDecode_d plus Decompress_q (FIPS 203, Sections 4.2.1 and 4.2.2) for one 256-coefficient polynomial.
- Consumes a packed byte stream and emits 12-bit coefficients in [0, 3328].
- Compression depth d is selected at run time per polynomial, from {1, 4, 5, 10, 11}.
- Sits between the ciphertext/key byte buffer and the NTT/polynomial RAM write port. Replaces one fixed-D combinational decompressor per depth.

Parameters:
- IN_W, 8, input byte-lane width in bits (only 8 is supported).
- N_COEF, 256, coefficients per polynomial.
- BUF_W, 24, bit-accumulator width; must be at least IN_W + 11 + 5 of headroom.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a polynomial; sampled only when idle
- d_sel  in  4  depth for this polynomial, latched on an accepted start; legal values 1, 4, 5, 10, 11
- busy  out  1  high from the accepted start until the last coefficient handshake
- err  out  1  one-cycle pulse when start arrives with an illegal d_sel
- in_data  in  8  packed byte, LSB-first bit order
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_coef  out  12  decompressed coefficient
- out_idx  out  8  coefficient index, 0..255
- out_last  out  1  high with index 255
- out_valid  out  1  coefficient valid
- out_ready  in  1  downstream accept
- done  out  1  one-cycle pulse in the cycle after the index-255 handshake

Behaviour:
- Reset (asynchronous, rst_n=0): FSM goes to IDLE. These all clear to 0: busy, err, in_ready, out_valid, out_last, done, out_coef, out_idx, the bit buffer, the bit count, the byte counter and the coefficient counter. Reset mid-polynomial abandons it; no partial done is issued.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start with a legal d_sel goes to RUN and latches d. start with an illegal d_sel pulses err and stays in IDLE.
  - start while busy is ignored.
- RUN:
  - in_ready = (bytes_taken < 32*d) && (bit_count + 8 <= BUF_W).
  - On an accepted byte, the byte is appended above the existing bits: buf |= in_data << bit_count, and bit_count increases by 8.
  - When bit_count >= d and the output register is empty or being drained this cycle, y = buf[d-1:0] is consumed. buf shifts right by d and bit_count decreases by d.
  - out_coef is registered as ((3329*y + 2^(d-1)) >> d)[11:0]. The product is 23 bits wide; y is zero-extended to 11 bits.
- Byte append and coefficient extraction in the same cycle are both legal. The net bit_count change is +8-d.
- Latency: a coefficient appears on out_valid in the cycle after its last bit is accepted on the byte port.
- Throughput: one coefficient per cycle while bits are available and out_ready=1.
  - d=1 drains one byte over 8 cycles.
  - d=11 requires about 1.375 bytes per coefficient.
- Output handshake: out_valid, out_coef, out_idx and out_last are held stable until out_ready. With out_ready=0, extraction stalls; the buffer keeps filling until it is full.
- Coefficient 0 is taken from the lowest bits of byte 0.
- Total bytes consumed = 32*d exactly. bit_count is 0 after index 255. No extra byte is ever accepted.
- After the index-255 handshake: the FSM goes through DRAIN for one cycle, then IDLE. done pulses and busy drops in that DRAIN cycle. in_ready is 0 from the cycle the 32*d-th byte is accepted.
- A start pulse on the same cycle as done is ignored; it is accepted from the next cycle.

Decomposition:
- Shared kyber_pkg.vh holds:
  - KYBER_Q = 3329 and KYBER_N = 256.
  - The legal-depth constants D1, D4, D5, D10, D11.
  - A function returning bytes-per-polynomial (32*d).
- Sub-module decompress_var: combinational; inputs are d (4 bits) and y (11 bits); output is result (12 bits). It selects the 2^(d-1) rounding constant and the shift by d via a case on d.
- The top level holds the FSM, the bit accumulator, the counters and the output register.

Test Plan:
- d=4, bytes 0x5A then 0xFF with out_ready=1 -> coefficients 2081 (y=0xA), 1040 (y=5), 3121, 3121. out_idx 0..3.
- d=1, 32 bytes: 0x01 then 31 bytes of 0x00 -> out_coef 1665 at idx 0 and 0 for idx 1..255. out_last and done are at idx 255. Exactly 32 bytes are accepted.
- d=10 all-ones and d=11 all-ones (320 and 352 bytes of 0xFF) -> every coefficient is 3326 (d=10) or 3327 (d=11). d=5 all-ones -> 3225.
- Backpressure: d=11 with out_ready toggling randomly and in_valid gapped -> sequence matches a golden model. Output held stable while stalled. in_ready=0 whenever bit_count+8 > 24.
- start with d_sel=3 -> err pulse, busy stays 0. A start while busy is ignored, with no change to d.
- rst_n asserted at idx 100 of a d=5 run -> all outputs are 0 immediately. A following d=4 run completes correctly from idx 0.
